// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side bundle for mem_arbiter.
// slave = arbiter side, master = requesters plus memory model.
interface mem_arbiter_if #(
    parameter int DATA_W = 32
);
    logic [1:0]        req;
    logic [1:0]        we;
    logic [31:0]       addr0;
    logic [31:0]       addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        gnt;
    logic [1:0]        rvalid;
    logic [DATA_W-1:0] rdata;
    logic              err;
    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_data;

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, mem_data,
        output gnt, rvalid, rdata, err, mem_addr, mem_wr_data, mem_write, mem_read
    );

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, mem_data,
        input  gnt, rvalid, rdata, err, mem_addr, mem_wr_data, mem_write, mem_read
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port data memory.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 wins ties.
//
// state  | meaning
// IDLE   | no access in flight; sample req
// ACCESS | drive memory strobes for the latched request, gnt to its port
// RESP   | rvalid/err to the served port; sample req again
module mem_arbiter #(
    parameter int DEPTH  = 32,
    parameter int DATA_W = 32
) (
    input logic        clock,
    input logic        reset,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic              id_q;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              in_range;
    logic              win_any;
    logic              win_id;
    logic              sample;
    logic [1:0]        gnt;
    logic [1:0]        rvalid;
    logic              err;
    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_write;
    logic              mem_read;
`ifdef MEM_ARB_RR_EN
    logic              last_q;
`endif

    // full 32-bit compare so aliased high addresses are still rejected
    assign in_range = (addr_q < DEPTH_W);
    assign win_any  = |bus.req;
    assign sample   = (state == IDLE) || (state == RESP);

    always_comb begin
        win_id = 1'b0;
        case (bus.req)
            2'b10:   win_id = 1'b1;
`ifdef MEM_ARB_RR_EN
            2'b11:   win_id = ~last_q;
`else
            2'b11:   win_id = 1'b0;
`endif
            default: win_id = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state <= state_nxt;
            if (sample && win_any) begin
                id_q    <= win_id;
                we_q    <= bus.we[win_id];
                addr_q  <= win_id ? bus.addr1 : bus.addr0;
                wdata_q <= win_id ? bus.wdata1 : bus.wdata0;
`ifdef MEM_ARB_RR_EN
                last_q  <= win_id;
`endif
            end
            if (state == ACCESS) begin
                err_q   <= ~in_range;
                rdata_q <= (in_range && !we_q) ? bus.mem_data : '0;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        gnt         = 2'b00;
        rvalid      = 2'b00;
        err         = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_write   = 1'b0;
        mem_read    = 1'b0;
        case (state)
            IDLE: begin
                if (win_any) state_nxt = ACCESS;
            end
            ACCESS: begin
                state_nxt   = RESP;
                gnt[id_q]   = 1'b1;
                mem_addr    = addr_q;
                mem_wr_data = wdata_q;
                mem_write   = in_range & we_q;
                mem_read    = in_range & ~we_q;
            end
            RESP: begin
                rvalid[id_q] = 1'b1;
                err          = err_q;
                state_nxt    = win_any ? ACCESS : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.gnt         = gnt;
    assign bus.rvalid      = rvalid;
    assign bus.err         = err;
    assign bus.rdata       = rdata_q;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wr_data = mem_wr_data;
    assign bus.mem_write   = mem_write;
    assign bus.mem_read    = mem_read;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then random traffic,
// compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;
    localparam int DEPTH  = 32;
    localparam int DATA_W = 32;
    localparam int AW     = $clog2(DEPTH);

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mem_arbiter_if #(.DATA_W(DATA_W)) bus ();

    mem_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // memory written on the falling edge inside ACCESS, read combinationally
    logic [DATA_W-1:0] tb_mem [DEPTH];
    always @(negedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) tb_mem[i] <= '0;
        end else if (bus.mem_write && bus.mem_addr < 32'(DEPTH)) begin
            tb_mem[bus.mem_addr[AW-1:0]] <= bus.mem_wr_data;
        end
    end
    assign bus.mem_data = tb_mem[bus.mem_addr[AW-1:0]];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: expected outputs of the current cycle plus in-flight transaction
    logic [31:0] ref_mem [DEPTH];
    logic [1:0]  e_gnt, e_rvalid;
    logic        e_err, e_mwrite, e_mread;
    logic [31:0] e_rdata, e_maddr, e_mwdata;
    logic [31:0] t_addr, t_wdata;
    logic        t_we;
    int          m_last;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [1:0] r, input int last);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
`ifdef MEM_ARB_RR_EN
        return 1 - last;
`else
        return 0;
`endif
    endfunction

    task automatic step();
        logic [1:0]  ng, nv;
        logic        ne, nwr, nrd, oob;
        logic [31:0] nd, na, nw;
        int          w;
        ng = 2'b00; nv = 2'b00; ne = 1'b0; nd = e_rdata;
        na = '0; nw = '0; nwr = 1'b0; nrd = 1'b0;
        if (reset) begin
            nd = '0;
            m_last = 1;
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        end else if (e_gnt != 2'b00) begin
            oob = (t_addr >= 32'(DEPTH));
            nv = e_gnt;
            ne = oob;
            if (!oob && t_we) ref_mem[t_addr[AW-1:0]] = t_wdata;
            nd = (!oob && !t_we) ? ref_mem[t_addr[AW-1:0]] : '0;
        end else if (bus.req != 2'b00) begin
            w = pick(bus.req, m_last);
            m_last  = w;
            t_addr  = (w == 1) ? bus.addr1 : bus.addr0;
            t_wdata = (w == 1) ? bus.wdata1 : bus.wdata0;
            t_we    = bus.we[w];
            oob = (t_addr >= 32'(DEPTH));
            ng  = (w == 1) ? 2'b10 : 2'b01;
            na  = t_addr;
            nw  = t_wdata;
            nwr = !oob && t_we;
            nrd = !oob && !t_we;
        end
        @(posedge clock);
        #1;
        e_gnt = ng; e_rvalid = nv; e_err = ne; e_rdata = nd;
        e_maddr = na; e_mwdata = nw; e_mwrite = nwr; e_mread = nrd;
        check_val("gnt",         32'(bus.gnt),        32'(e_gnt));
        check_val("rvalid",      32'(bus.rvalid),     32'(e_rvalid));
        check_val("err",         32'(bus.err),        32'(e_err));
        check_val("rdata",       bus.rdata,           e_rdata);
        check_val("mem_addr",    bus.mem_addr,        e_maddr);
        check_val("mem_wr_data", bus.mem_wr_data,     e_mwdata);
        check_val("mem_write",   32'(bus.mem_write),  32'(e_mwrite));
        check_val("mem_read",    32'(bus.mem_read),   32'(e_mread));
    endtask

    task automatic issue(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.req[p] = 1'b1;
        bus.we[p]  = w;
        if (p == 0) begin
            bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return 32'd32 + 32'($urandom_range(0, 15));
        if (r == 1) return 32'h0001_0000 | 32'($urandom_range(0, DEPTH - 1));
        return 32'($urandom_range(0, DEPTH - 1));
    endfunction

    logic [1:0] gseq [6];
    logic [1:0] prev_gnt;
    int         gcount;

    initial begin
        bus.req = 2'b00; bus.we = 2'b00;
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        e_gnt = '0; e_rvalid = '0; e_err = 1'b0; e_rdata = '0;
        e_maddr = '0; e_mwdata = '0; e_mwrite = 1'b0; e_mread = 1'b0;
        t_addr = '0; t_wdata = '0; t_we = 1'b0; m_last = 1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        // reset, then idle
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // port 1 reads addr 0
        issue(1, 1'b0, 32'd0, 32'h1234_5678);
        step();
        check_val("p1_rd_gnt", 32'(bus.gnt), 32'h2);
        check_val("p1_rd_strobe", 32'(bus.mem_read), 32'h1);
        step();
        check_val("p1_rd_rvalid", 32'(bus.rvalid), 32'h2);
        check_val("p1_rd_rdata", bus.rdata, 32'h0);
        bus.req[1] = 1'b0;
        step();

        // port 0 writes, port 1 reads back on the next RESP
        issue(0, 1'b1, 32'd5, 32'hDEADBEEF);
        step();
        check_val("wr_strobe", 32'(bus.mem_write), 32'h1);
        issue(1, 1'b0, 32'd5, 32'h0);
        step();
        check_val("wr_rvalid", 32'(bus.rvalid), 32'h1);
        bus.req[0] = 1'b0;
        step();
        step();
        check_val("raw_rvalid", 32'(bus.rvalid), 32'h2);
        check_val("raw_rdata", bus.rdata, 32'hDEADBEEF);
        bus.req[1] = 1'b0;
        step(); step();

        // both ports hold reads
        for (int i = 0; i < 6; i++) gseq[i] = 2'b00;
        gcount = 0;
        issue(0, 1'b0, 32'd1, 32'h0);
        issue(1, 1'b0, 32'd2, 32'h0);
        for (int i = 0; i < 13; i++) begin
            step();
            if (bus.gnt != 2'b00 && gcount < 6) begin
                gseq[gcount] = bus.gnt;
                gcount++;
            end
        end
        for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_RR_EN
            check_val($sformatf("tie_gnt%0d", i), 32'(gseq[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
`else
            check_val($sformatf("tie_gnt%0d", i), 32'(gseq[i]), 32'h1);
`endif
        end
        bus.req = 2'b00;
        step(); step(); step();

        // out-of-range read
        issue(0, 1'b0, 32'd40, 32'h0);
        step();
        check_val("oob_strobes", {30'b0, bus.mem_write, bus.mem_read}, 32'h0);
        step();
        check_val("oob_rvalid", 32'(bus.rvalid), 32'h1);
        check_val("oob_err", 32'(bus.err), 32'h1);
        check_val("oob_rdata", bus.rdata, 32'h0);
        bus.req[0] = 1'b0;
        step(); step();

        // reset during ACCESS of a port 1 read
        issue(1, 1'b0, 32'd5, 32'h0);
        step();
        check_val("rst_pre_gnt", 32'(bus.gnt), 32'h2);
        reset = 1'b1;
        bus.req[1] = 1'b0;
        step();
        check_val("rst_rvalid", 32'(bus.rvalid), 32'h0);
        reset = 1'b0;
        step();
        check_val("rst_no_rvalid", 32'(bus.rvalid), 32'h0);
        issue(0, 1'b0, 32'd5, 32'h0);
        step();
        check_val("rst_post_gnt", 32'(bus.gnt), 32'h1);
        bus.req[0] = 1'b0;
        step(); step();

        // random traffic; a port changes its request only in the cycle after its gnt
        prev_gnt = 2'b00;
        for (int c = 0; c < 500; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (prev_gnt[p]) begin
                    if ($urandom_range(0, 2) != 0) issue(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
                    else bus.req[p] = 1'b0;
                end else if (!bus.req[p] && $urandom_range(0, 3) == 0) begin
                    issue(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
                end
            end
            prev_gnt = e_gnt;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

- Two-port arbiter and sequencer sitting in front of the single-port 32x32 data memory.
- Port 0 is the load/store unit; port 1 is the instruction fetch / program loader.
- Serialises requests into single-cycle memory strobes and registers read data back to the winning requester.
- Range-checks addresses and arbitrates simultaneous requests by fixed or round-robin priority.

## Interface
Parameters:
- DEPTH, 32, number of memory words; legal word addresses are 0..DEPTH-1.
- DATA_W, 32, data width.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  2  per-port request; held with its fields until gnt for that port.
- we  in  2  per-port write enable (1 = write, 0 = read).
- addr0, addr1  in  32  per-port word address.
- wdata0, wdata1  in  DATA_W  per-port write data.
- gnt  out  2  one-hot; high for the single ACCESS cycle of the granted port.
- rvalid  out  2  one-hot; high for one cycle in RESP for the served port (reads and writes).
- rdata  out  DATA_W  read data; valid when rvalid is nonzero.
- err  out  1  high with rvalid when the served address was out of range.
- mem_addr  out  32  memory address.
- mem_wr_data  out  DATA_W  memory write data.
- mem_write, mem_read  out  1  memory strobes.
- mem_data  in  DATA_W  combinational memory read data.

## Operation
- FSM states:
  - IDLE: sample req. If any request is present, pick a winner, latch its addr/we/wdata and port id, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: drive mem_addr and mem_wr_data from the latch. gnt[id]=1.
    - In range: mem_write=we, mem_read=~we.
    - Out of range (addr >= DEPTH): both strobes stay 0 and an error flag is latched.
    - On the closing edge, capture mem_data into rdata for reads. For writes and errors, rdata is set to 0.
    - Always go to RESP.
  - RESP: rvalid[id]=1; err=error flag. Sample req again, exactly as in IDLE. A winner goes to ACCESS; no request returns to IDLE.
- Requester rule: req is sampled only in IDLE or RESP cycles. A requester may change or drop req starting the cycle after its gnt.
- Requests present during ACCESS are never lost; they are evaluated in the following RESP cycle.
- Arbitration when both req bits are set: see Configuration. A single request always wins.
- mem_addr and mem_wr_data are 0 outside ACCESS. Strobes are never high outside ACCESS.
- mem_addr passes the full 32-bit address unchanged; the range check compares all 32 bits against DEPTH.

## Timing
- Reset values: state=IDLE, gnt=0, rvalid=0, rdata=0, err=0, mem_*=0, priority pointer=port 0.
- Latency: req in cycle N (IDLE) -> gnt and strobes in N+1 -> rvalid and rdata in N+2.
- Throughput: continuous requests give one access per 2 cycles (ACCESS/RESP alternate).
- The memory writes on the falling edge inside ACCESS. A read issued in the next ACCESS cycle returns the new value, so read-after-write is coherent.
- Reset asserted in any state: the next cycle is IDLE with all outputs 0. The in-flight access is dropped with no rvalid. A write whose ACCESS cycle coincides with reset is undefined (the memory is reset too).
- rdata holds its last value while rvalid=0.

## Configuration
- MEM_ARB_RR_EN defined: round-robin.
  - On a tie, grant the port not granted most recently.
  - The pointer updates on every grant, including out-of-range accesses.
  - The pointer resets to favour port 0.
- MEM_ARB_RR_EN undefined: fixed priority, port 0 always wins ties. The pointer logic is removed.

## Test plan
- Reset then idle: all outputs 0 for 5 cycles, including mem_read.
- Port 1 reads addr 0 after reset:
  - gnt=2'b10 one cycle later, with mem_read=1 and mem_addr=0.
  - rvalid=2'b10 next cycle with rdata=0.
- Port 0 writes 32'hDEADBEEF to addr 5, then port 1 reads addr 5 on the next RESP:
  - Write ACCESS has mem_write=1.
  - The read returns rdata=32'hDEADBEEF with rvalid=2'b10, 2 cycles after the write's rvalid.
- Both ports hold reads for 6 grants:
  - With MEM_ARB_RR_EN, grants alternate 01,10,01,10,01,10.
  - Without it, port 0 receives all 6 grants while its req stays high.
- Port 0 reads addr 40 (DEPTH=32): mem strobes stay 0 in ACCESS, then rvalid=2'b01, err=1, rdata=0.
- Reset asserted during ACCESS of a port 1 read: no rvalid follows, outputs are 0 the next cycle, and a new req is granted normally after reset drops.
